// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - shared KBSR bit positions, receiver FSM states and status packing
package kbd_pkg;

  localparam int KBSR_READY_BIT = 15;
  localparam int KBSR_IE_BIT    = 14;
  localparam int KBSR_OVR_BIT   = 13;
  localparam int KBSR_RXEN_BIT  = 0;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_FULL  = 2'd2
  } rx_state_t;

  function automatic logic [15:0] kbsr_pack(input logic ready, input logic ie,
                                            input logic ovr, input logic rxen);
    logic [15:0] v;
    v                 = 16'h0000;
    v[KBSR_READY_BIT] = ready;
    v[KBSR_IE_BIT]    = ie;
    v[KBSR_OVR_BIT]   = ovr;
    v[KBSR_RXEN_BIT]  = rxen;
    return v;
  endfunction

endpackage

// File: rtl/kbd_rx_ctrl_if.sv
// rtl/kbd_rx_ctrl_if.sv - keyboard receive path and memory-mapped bus bundle
interface kbd_rx_ctrl_if;

  logic        rx_dv;
  logic [15:0] rx_byte;
  logic        recieve;
  logic [15:0] addr;
  logic        rd_en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        intr;

  // master is the bus/receiver side driving the controller
  modport master (
    output rx_dv, rx_byte, addr, rd_en, wr_en, wr_data,
    input  recieve, rd_data, rd_valid, intr
  );

  modport slave (
    input  rx_dv, rx_byte, addr, rd_en, wr_en, wr_data,
    output recieve, rd_data, rd_valid, intr
  );

endinterface

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO; a push into a full FIFO succeeds when a pop coincides
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          i_Clock,
  input  logic          i_Reset_n,
  input  logic          i_Push,
  input  logic          i_Pop,
  input  logic [7:0]    i_Data,
  output logic [7:0]    o_Data,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [CW-1:0] o_Count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_Full  = (r_count == FULL_CNT);
  assign o_Empty = (r_count == '0);
  assign o_Count = r_count;
  assign o_Data  = r_mem[r_rd_ptr];

  assign w_pop  = i_Pop & ~o_Empty;
  assign w_push = i_Push & (~o_Full | w_pop);

  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Data;
    end
  end

  // pointers wrap for free because DEPTH is a power of two
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_rx_ctrl.sv
// rtl/kbd_rx_ctrl.sv - keyboard receive controller: KBSR/KBDR register decode, receive FSM, interrupt
module kbd_rx_ctrl
  import kbd_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] ADDR_KBSR  = 16'hFE00,
  parameter logic [15:0] ADDR_KBDR  = 16'hFE02
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_DV,
  input  logic [15:0] i_Rx_Byte,
  output logic        o_Recieve,
  input  logic [15:0] i_Addr,
  input  logic        i_Rd_En,
  input  logic        i_Wr_En,
  input  logic [15:0] i_Wr_Data,
  output logic [15:0] o_Rd_Data,
  output logic        o_Rd_Valid,
  output logic        o_Intr
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic          r_ie;
  logic          r_ovr;
  logic          r_rxen;
  logic          r_rd_valid;
  logic [15:0]   r_rd_data;
  logic          r_recieve;
  logic          r_intr;
  rx_state_t     r_state;
  rx_state_t     w_next;

  logic          w_kbsr_hit;
  logic          w_kbdr_hit;
  logic          w_wr;
  logic          w_rd;
  logic          w_kbsr_wr;
  logic          w_pop;
  logic          w_ovr_set;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic [15:0]   w_kbsr_val;
  logic          w_unused_bits;

  assign w_kbsr_hit = (i_Addr == ADDR_KBSR);
  assign w_kbdr_hit = (i_Addr == ADDR_KBDR);
  // a combined read+write strobe is treated as a write alone
  assign w_wr       = i_Wr_En;
  assign w_rd       = i_Rd_En & ~i_Wr_En;
  assign w_kbsr_wr  = w_wr & w_kbsr_hit;
  assign w_pop      = w_rd & w_kbdr_hit & ~w_empty;
  assign w_ovr_set  = i_Rx_DV & w_full & ~w_pop;
  assign w_kbsr_val = kbsr_pack(~w_empty, r_ie, r_ovr, r_rxen);

  assign w_unused_bits = ^{i_Rx_Byte[15:8], i_Wr_Data[15], i_Wr_Data[12:1]};

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock   (i_Clock),
    .i_Reset_n (i_Reset_n),
    .i_Push    (i_Rx_DV),
    .i_Pop     (w_pop),
    .i_Data    (i_Rx_Byte[7:0]),
    .o_Data    (w_head),
    .o_Full    (w_full),
    .o_Empty   (w_empty),
    .o_Count   (w_count)
  );

  // OVR set by a dropped byte wins over a same-cycle write-1-to-clear
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_ie   <= 1'b0;
      r_ovr  <= 1'b0;
      r_rxen <= 1'b0;
    end else begin
      if (w_kbsr_wr) begin
        r_ie   <= i_Wr_Data[KBSR_IE_BIT];
        r_rxen <= i_Wr_Data[KBSR_RXEN_BIT];
      end
      if (w_ovr_set) begin
        r_ovr <= 1'b1;
      end else if (w_kbsr_wr && i_Wr_Data[KBSR_OVR_BIT]) begin
        r_ovr <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= 16'h0000;
    end else begin
      r_rd_valid <= w_rd & (w_kbsr_hit | w_kbdr_hit);
      if (w_rd && w_kbsr_hit) begin
        r_rd_data <= w_kbsr_val;
      end else if (w_rd && w_kbdr_hit) begin
        r_rd_data <= {8'h00, (w_empty ? 8'h00 : w_head)};
      end else begin
        r_rd_data <= 16'h0000;
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!r_rxen) begin
      w_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF:   w_next = ST_ARMED;
        ST_ARMED: if (w_count == FULL_CNT) w_next = ST_FULL;
        ST_FULL:  if (w_count < FULL_CNT)  w_next = ST_ARMED;
        default:  w_next = ST_OFF;
      endcase
    end
  end

  // registered from the next state so o_Recieve lines up with the ARMED state
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_recieve <= 1'b0;
      r_intr    <= 1'b0;
    end else begin
      r_recieve <= (w_next == ST_ARMED);
      r_intr    <= r_ie & ~w_empty;
    end
  end

  assign o_Recieve  = r_recieve;
  assign o_Intr     = r_intr;
  assign o_Rd_Valid = r_rd_valid;
  assign o_Rd_Data  = r_rd_data;

endmodule

// File: tb/tb_kbd_rx_ctrl.sv
// tb/tb_kbd_rx_ctrl.sv - directed self-checking bench for kbd_rx_ctrl
module tb_kbd_rx_ctrl;

  localparam logic [15:0] KBSR = 16'hFE00;
  localparam logic [15:0] KBDR = 16'hFE02;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  kbd_rx_ctrl_if bus ();

  kbd_rx_ctrl #(
    .FIFO_DEPTH (4),
    .ADDR_KBSR  (KBSR),
    .ADDR_KBDR  (KBDR)
  ) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_Rx_DV    (bus.rx_dv),
    .i_Rx_Byte  (bus.rx_byte),
    .o_Recieve  (bus.recieve),
    .i_Addr     (bus.addr),
    .i_Rd_En    (bus.rd_en),
    .i_Wr_En    (bus.wr_en),
    .i_Wr_Data  (bus.wr_data),
    .o_Rd_Data  (bus.rd_data),
    .o_Rd_Valid (bus.rd_valid),
    .o_Intr     (bus.intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 16'h%04h expected 16'h%04h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.addr    = a;
    bus.wr_data = d;
    bus.wr_en   = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic v);
    @(negedge clk);
    bus.addr  = a;
    bus.rd_en = 1'b1;
    @(posedge clk);
    #1;
    d = bus.rd_data;
    v = bus.rd_valid;
    bus.rd_en = 1'b0;
  endtask

  task automatic rx_push(input logic [15:0] b);
    @(negedge clk);
    bus.rx_byte = b;
    bus.rx_dv   = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_dv   = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        v;
    bus_read(a, d, v);
    check_eq({tag, "_valid"}, {15'd0, v}, 16'h0001);
    check_eq(tag, d, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] rd;
  logic        rv;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.rx_dv = 1'b0;
    bus.rx_byte = 16'h0000;
    bus.addr = 16'h0000;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_data = 16'h0000;

    repeat (3) tick();
    check_eq("rst_recieve", {15'd0, bus.recieve}, 16'h0000);
    check_eq("rst_intr", {15'd0, bus.intr}, 16'h0000);
    check_eq("rst_rd_valid", {15'd0, bus.rd_valid}, 16'h0000);
    check_eq("rst_rd_data", bus.rd_data, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("kbsr_reset", KBSR, 16'h0000);

    // basic receive and drain
    bus_write(KBSR, 16'h0001);
    repeat (2) tick();
    check_eq("armed_recieve", {15'd0, bus.recieve}, 16'h0001);
    rx_push(16'h0041);
    read_check("kbsr_ready", KBSR, 16'h8001);
    read_check("kbdr_41", KBDR, 16'h0041);
    read_check("kbsr_drained", KBSR, 16'h0001);

    // empty KBDR read and one-cycle valid
    read_check("kbdr_empty", KBDR, 16'h0000);
    tick();
    check_eq("valid_one_cycle", {15'd0, bus.rd_valid}, 16'h0000);
    check_eq("data_idle_zero", bus.rd_data, 16'h0000);

    // interrupt timing
    bus_write(KBSR, 16'h4001);
    rx_push(16'h0035);
    check_eq("intr_not_yet", {15'd0, bus.intr}, 16'h0000);
    tick();
    check_eq("intr_set", {15'd0, bus.intr}, 16'h0001);
    read_check("kbdr_35", KBDR, 16'h0035);
    check_eq("intr_still", {15'd0, bus.intr}, 16'h0001);
    tick();
    check_eq("intr_clear", {15'd0, bus.intr}, 16'h0000);
    bus_write(KBSR, 16'h0001);

    // fill, overflow, drain
    for (int i = 1; i <= 4; i++) rx_push(16'(i));
    repeat (2) tick();
    check_eq("full_recieve_low", {15'd0, bus.recieve}, 16'h0000);
    rx_push(16'h0005);
    read_check("kbsr_ovr", KBSR, 16'hA001);
    for (int i = 1; i <= 4; i++) read_check("kbdr_fill", KBDR, 16'(i));
    read_check("kbsr_ovr_empty", KBSR, 16'h2001);
    bus_write(KBSR, 16'h2001);
    read_check("kbsr_ovr_cleared", KBSR, 16'h0001);
    tick();
    check_eq("rearmed_recieve", {15'd0, bus.recieve}, 16'h0001);

    // push into full FIFO coincident with pop
    for (int i = 1; i <= 4; i++) rx_push(16'(i));
    @(negedge clk);
    bus.addr = KBDR;
    bus.rd_en = 1'b1;
    bus.rx_byte = 16'h0099;
    bus.rx_dv = 1'b1;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.rx_dv = 1'b0;
    check_eq("simul_valid", {15'd0, bus.rd_valid}, 16'h0001);
    check_eq("simul_data", bus.rd_data, 16'h0001);
    read_check("kbsr_no_ovr", KBSR, 16'h8001);
    read_check("kbdr_s2", KBDR, 16'h0002);
    read_check("kbdr_s3", KBDR, 16'h0003);
    read_check("kbdr_s4", KBDR, 16'h0004);
    read_check("kbdr_s99", KBDR, 16'h0099);
    read_check("kbsr_after_simul", KBSR, 16'h0001);

    // unmapped read, ignored KBDR write, combined read+write
    bus_read(16'h1234, rd, rv);
    check_eq("unmapped_valid", {15'd0, rv}, 16'h0000);
    bus_write(KBDR, 16'h0055);
    read_check("kbdr_write_ignored", KBDR, 16'h0000);
    @(negedge clk);
    bus.addr = KBSR;
    bus.wr_data = 16'h4001;
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    check_eq("rdwr_no_valid", {15'd0, bus.rd_valid}, 16'h0000);
    read_check("rdwr_wrote", KBSR, 16'h4001);

    // asynchronous reset mid-cycle with data queued
    rx_push(16'h0011);
    rx_push(16'h0022);
    repeat (2) tick();
    check_eq("pre_rst_intr", {15'd0, bus.intr}, 16'h0001);
    check_eq("pre_rst_recieve", {15'd0, bus.recieve}, 16'h0001);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_intr", {15'd0, bus.intr}, 16'h0000);
    check_eq("async_rst_recieve", {15'd0, bus.recieve}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_no_valid", {15'd0, bus.rd_valid}, 16'h0000);
    read_check("kbsr_post_rst", KBSR, 16'h0000);
    check_eq("post_rst_intr", {15'd0, bus.intr}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
